wino_filter_transform_pipe: RTL and testbench
=============================================

# wino_filter_transform_pipe

Streaming, parametrised Winograd F(2,3) filter-transform engine that computes U = G·g·Gᵀ for one 3×3 kernel per accepted beat. It adds a valid/ready elastic pipeline with backpressure, a per-beat mode select (Winograd or bypass), output saturation to WO bits, and a channel counter with last-of-group tagging. It sits between the weight buffer and the Winograd element-wise multiplier array.

## Interface
- WI, 8: signed input element width.
- WO, 12: signed output element width, 4 ≤ WO.
- NCH, 4: kernels per group; sets the channel counter wrap, NCH ≥ 1.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_mode  in  1  0 = Winograd transform, 1 = bypass; sampled with the beat.
- filter  in  9*WI  3×3 kernel; element (r,c) at [(3r+c)*WI +: WI], signed.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- filter_out  out  16*WO  4×4 result; element (i,j) at [(15-(4i+j))*WO +: WO], so (0,0) is in the MSBs.
- out_ch  out  $clog2(NCH) (min 1)  channel index of the output beat.
- out_last  out  1  out_ch == NCH-1.
- out_sat  out  1  at least one element of this beat was clipped.

## Operation
- Accept happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Stage 1 (row pass, G·g), internal width WI+3, values sign-extended. Row r0 = g row 0. r1 = (row0+row1+row2)>>>1. r2 = (row0−row1+row2)>>>1. r3 = row 2. Each is computed column-wise per column c.
- Stage 2 (column pass, ·Gᵀ), per stage-1 row k=0..3, width WI+3. U(k,0) = a0. U(k,1) = (a0+a1+a2)>>>1. U(k,2) = (a0−a1+a2)>>>1. U(k,3) = a2.
- >>> is an arithmetic shift, so results round toward −∞.
- Saturation in stage 2: values above 2^(WO-1)−1 clip to that value, and values below −2^(WO-1) clip to that value. out_sat is the OR of all 16 clip events.
- Bypass mode: U(i,j) = g(i,j) for i,j<3, sign-extended then saturated. Row 3 and column 3 are 0.
- The mode bit travels with the beat through both stages. Mixed-mode streams are legal.
- Channel counter: increments on every accept and wraps NCH-1 → 0. The value is captured into the beat at accept and emerges as out_ch / out_last.

## Timing
- Two-stage pipeline with one valid bit per stage (s1_v, s2_v). Output registers are stage 2.
- Stage 2 loads when s1_v && (!s2_v || out_ready).
- Stage 1 loads when in_valid && (!s1_v || stage-2 loads).
- in_ready = !s1_v || (!s2_v || out_ready). It is combinational from out_ready only.
- Latency: accept at cycle N gives out_valid at cycle N+2 when there is no backpressure. Throughput is 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, filter_out, out_ch, out_last and out_sat hold stable. Up to 2 beats are stored. in_ready drops once both stages are full.
- A simultaneous accept and output transfer with a full pipe is allowed, with no bubble and no loss.
- Reset (any cycle, including mid-stream): s1_v = s2_v = 0, channel counter = 0, filter_out = 0, out_ch = 0, out_last = 0, out_sat = 0. In-flight beats are dropped. in_ready = 1 in the cycle after reset is released.
- No output changes while out_valid = 0, except on reset.

## Test plan
- All-ones kernel, mode 0, out_ready = 1 → after 2 cycles, rows [1,1,0,1], [1,1,0,1], [0,0,0,0], [1,1,0,1], out_sat = 0.
- All −1 kernel, mode 0 → rows [−1,−2,−1,−1], [−2,−3,−1,−2], [−1,−2,−1,−1], [−1,−2,−1,−1], which checks floor rounding.
- WO=6, all-127 kernel → (0,0) = 31, (1,1) = 31 (raw 285), out_sat = 1. Same with WO=12 → (1,1) = 285, out_sat = 0.
- Mode 1 with kernel g(r,c) = 3r+c−4 → U(i,j) = g(i,j) for i,j<3, row 3 and column 3 = 0.
- NCH=4, 9 back-to-back beats, out_ready toggling randomly → no loss or duplication, order preserved, out_ch sequence 0,1,2,3,0,1,2,3,0, out_last on beats 4 and 8, outputs stable while stalled.
- Assert rst with 2 beats in flight → out_valid = 0 the next cycle, the next accepted beat gets out_ch = 0.

Source files
------------

// File: rtl/wino_filter_transform_pipe_if.sv
// Handshake and data bundle for the Winograd F(2,3) filter-transform pipe.
// "slave" is the transform block; "master" is the side that feeds kernels in
// and drains transformed tiles.
interface wino_filter_transform_pipe_if #(
  parameter int WI  = 8,
  parameter int WO  = 12,
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                in_valid;
  logic                in_ready;
  logic                in_mode;
  logic [9*WI-1:0]     filter;
  logic                out_valid;
  logic                out_ready;
  logic [16*WO-1:0]    filter_out;
  logic [CW-1:0]       out_ch;
  logic                out_last;
  logic                out_sat;

  modport master (
    output in_valid, in_mode, filter, out_ready,
    input  in_ready, out_valid, filter_out, out_ch, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_mode, filter, out_ready,
    output in_ready, out_valid, filter_out, out_ch, out_last, out_sat
  );
endinterface

// File: rtl/wino_filter_transform_pipe.sv
// Winograd F(2,3) filter transform U = G*g*G^T, two-stage elastic pipeline.
// Stage 1 applies G down the columns of g, stage 2 applies G^T along the rows
// of the stage-1 result and saturates to WO bits. A bypass bit per beat
// passes the kernel straight through (zero-padded to 4x4).

// One 3-point F(2,3) transform: [a0, (a0+a1+a2)>>>1, (a0-a1+a2)>>>1, a2].
// WU must be wide enough to hold the 3-term sum without overflow.
module wino_f23_lane #(
  parameter int W  = 8,
  parameter int WU = W + 3
) (
  input  logic signed [W-1:0]  a0_i,
  input  logic signed [W-1:0]  a1_i,
  input  logic signed [W-1:0]  a2_i,
  output logic signed [WU-1:0] u0_o,
  output logic signed [WU-1:0] u1_o,
  output logic signed [WU-1:0] u2_o,
  output logic signed [WU-1:0] u3_o
);
  logic signed [WU-1:0] x0, x1, x2, sp, sm;

  assign x0 = {{(WU-W){a0_i[W-1]}}, a0_i};
  assign x1 = {{(WU-W){a1_i[W-1]}}, a1_i};
  assign x2 = {{(WU-W){a2_i[W-1]}}, a2_i};
  assign sp = x0 + x1 + x2;
  assign sm = x0 - x1 + x2;

  // Arithmetic shift: halves round toward -inf.
  assign u0_o = x0;
  assign u1_o = sp >>> 1;
  assign u2_o = sm >>> 1;
  assign u3_o = x2;
endmodule

module wino_filter_transform_pipe #(
  parameter int WI  = 8,
  parameter int WO  = 12,
  parameter int NCH = 4
) (
  input logic                       clk_i,
  input logic                       rst_i,
  wino_filter_transform_pipe_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int W1 = WI + 3;                        // stage-1 element width
  localparam int W2 = WI + 5;                        // stage-2 pre-saturation width
  localparam int WX = ((W2 > WO) ? W2 : WO) + 1;     // compare width for clipping
  localparam logic signed [WX-1:0] SMAX = WX'((64'sd1 <<< (WO-1)) - 64'sd1);
  localparam logic signed [WX-1:0] SMIN = ~SMAX;     // -2^(WO-1)
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);

  // ---------------- control ----------------
  logic          s1_v_q, s2_v_q;
  logic          s1_load, s2_load;
  logic [CW-1:0] ch_q;

  // Elastic handshake: stage 2 drains when empty or downstream takes it;
  // stage 1 refills when empty or moving into stage 2.
  always_comb begin
    s2_load      = s1_v_q && (!s2_v_q || bus.out_ready);
    s1_load      = bus.in_valid && (!s1_v_q || s2_load);
    bus.in_ready = !s1_v_q || !s2_v_q || bus.out_ready;
  end

  // Valid bits and channel counter (advances on every accepted beat).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      if (s1_load)      s1_v_q <= 1'b1;
      else if (s2_load) s1_v_q <= 1'b0;
      if (s2_load)            s2_v_q <= 1'b1;
      else if (bus.out_ready) s2_v_q <= 1'b0;
      if (s1_load) ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
    end
  end

  // ---------------- stage 1: G * g ----------------
  // g[r][c] lands exactly on filter[(3r+c)*WI +: WI].
  logic [2:0][2:0][WI-1:0] g;
  logic [3:0][2:0][W1-1:0] s1x, s1_d, s1_q;
  logic                    s1_mode_q;
  logic [CW-1:0]           s1_ch_q;

  assign g = bus.filter;

  for (genvar c = 0; c < 3; c++) begin : g_col
    wino_f23_lane #(.W(WI), .WU(W1)) u_lane (
      .a0_i (g[0][c]),
      .a1_i (g[1][c]),
      .a2_i (g[2][c]),
      .u0_o (s1x[0][c]),
      .u1_o (s1x[1][c]),
      .u2_o (s1x[2][c]),
      .u3_o (s1x[3][c])
    );
  end

  // Bypass keeps g sign-extended in rows 0..2 and zeroes row 3.
  always_comb begin
    s1_d = s1x;
    if (bus.in_mode) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s1_d[r][c] = {{3{g[r][c][WI-1]}}, g[r][c]};
      s1_d[3] = '0;
    end
  end

  // Stage-1 payload; only meaningful while s1_v_q is set.
  always_ff @(posedge clk_i) begin
    if (s1_load) begin
      s1_q      <= s1_d;
      s1_mode_q <= bus.in_mode;
      s1_ch_q   <= ch_q;
    end
  end

  // ---------------- stage 2: (G*g) * G^T ----------------
  logic [3:0][3:0][W2-1:0] s2x, s2_pre;
  logic [15:0][WO-1:0]     sat_val;
  logic [15:0]             clip;
  logic signed [WX-1:0]    ext;

  for (genvar k = 0; k < 4; k++) begin : g_row
    wino_f23_lane #(.W(W1), .WU(W2)) u_lane (
      .a0_i (s1_q[k][0]),
      .a1_i (s1_q[k][1]),
      .a2_i (s1_q[k][2]),
      .u0_o (s2x[k][0]),
      .u1_o (s2x[k][1]),
      .u2_o (s2x[k][2]),
      .u3_o (s2x[k][3])
    );
  end

  // Bypass passes stage-1 columns 0..2 through and zeroes column 3.
  always_comb begin
    s2_pre = s2x;
    if (s1_mode_q) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 3; j++)
          s2_pre[k][j] = {{2{s1_q[k][j][W1-1]}}, s1_q[k][j]};
        s2_pre[k][3] = '0;
      end
    end
  end

  // Clip each element to the signed WO range; element (i,j) goes to slot
  // 15-(4i+j) so that (0,0) ends up in the MSBs of filter_out.
  always_comb begin
    sat_val = '0;
    clip    = '0;
    ext     = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        ext = {{(WX-W2){s2_pre[k][j][W2-1]}}, s2_pre[k][j]};
        if (ext > SMAX) begin
          sat_val[15-(4*k+j)] = SMAX[WO-1:0];
          clip[15-(4*k+j)]    = 1'b1;
        end else if (ext < SMIN) begin
          sat_val[15-(4*k+j)] = SMIN[WO-1:0];
          clip[15-(4*k+j)]    = 1'b1;
        end else begin
          sat_val[15-(4*k+j)] = ext[WO-1:0];
        end
      end
    end
  end

  logic [15:0][WO-1:0] fo_q;
  logic [CW-1:0]       och_q;
  logic                olast_q, osat_q;

  // Output registers: change only when a new beat moves in, so they hold
  // steady under backpressure and while out_valid is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fo_q    <= '0;
      och_q   <= '0;
      olast_q <= 1'b0;
      osat_q  <= 1'b0;
    end else if (s2_load) begin
      fo_q    <= sat_val;
      och_q   <= s1_ch_q;
      olast_q <= (s1_ch_q == CH_LAST);
      osat_q  <= |clip;
    end
  end

  assign bus.out_valid  = s2_v_q;
  assign bus.filter_out = fo_q;
  assign bus.out_ch     = och_q;
  assign bus.out_last   = olast_q;
  assign bus.out_sat    = osat_q;
endmodule

// File: tb/tb_wino_filter_transform_pipe.sv
// Directed bench for wino_filter_transform_pipe: hand-computed tiles,
// saturation on a narrow (WO=6) twin, backpressured stream, mid-stream reset.
module tb_wino_filter_transform_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mode, out_ready;
  logic [71:0] filter;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wino_filter_transform_pipe_if #(.WI(8), .WO(12), .NCH(4)) bus  ();
  wino_filter_transform_pipe_if #(.WI(8), .WO(6),  .NCH(4)) bus6 ();

  assign bus.in_valid   = in_valid;
  assign bus.in_mode    = in_mode;
  assign bus.filter     = filter;
  assign bus.out_ready  = out_ready;
  assign bus6.in_valid  = in_valid;
  assign bus6.in_mode   = in_mode;
  assign bus6.filter    = filter;
  assign bus6.out_ready = out_ready;

  wino_filter_transform_pipe #(.WI(8), .WO(12), .NCH(4)) u_dut (
    .clk_i (clk), .rst_i (rst), .bus (bus)
  );
  wino_filter_transform_pipe #(.WI(8), .WO(6), .NCH(4)) u_dut6 (
    .clk_i (clk), .rst_i (rst), .bus (bus6)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected 4x4 tile, element (i,j) = e[4i+j], (0,0) in the MSBs.
  function automatic logic [191:0] pk12(input int e[16]);
    logic [191:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[(15-i)*12 +: 12] = 12'(e[i]);
    return r;
  endfunction

  function automatic logic [71:0] kconst(input int v);
    logic [71:0] f;
    for (int i = 0; i < 9; i++) f[i*8 +: 8] = 8'(v);
    return f;
  endfunction

  // Bypass of a constant kernel: v in the top-left 3x3, zero elsewhere.
  function automatic logic [191:0] bp_const(input int v);
    int e[16];
    for (int i = 0; i < 16; i++) e[i] = ((i % 4) < 3 && i < 12) ? v : 0;
    return pk12(e);
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; filter = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called just after a rising edge. Sends one beat with out_ready high,
  // checks the 2-cycle latency and returns at the negedge of the output cycle.
  task automatic xfer1(input logic m, input logic [71:0] f);
    in_valid = 1'b1; in_mode = m; filter = f; out_ready = 1'b1;
    @(negedge clk); chk("acc_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; filter = '0;
    @(negedge clk); chk("lat_n1", bus.out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_n2", bus.out_valid, 1);
  endtask

  int e[16];
  logic [71:0] fk;
  int tx, rx;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_ovalid", bus.out_valid, 0);
    chk("rst_irdy",   bus.in_ready, 1);
    chk("rst_fo",     bus.filter_out, 0);
    chk("rst_ch",     bus.out_ch, 0);
    chk("rst_last",   bus.out_last, 0);
    chk("rst_sat",    bus.out_sat, 0);
    @(posedge clk); #1;

    // all ones, Winograd
    xfer1(1'b0, kconst(1));
    e = '{1,1,0,1, 1,1,0,1, 0,0,0,0, 1,1,0,1};
    chk("ones_fo",  bus.filter_out, pk12(e));
    chk("ones_sat", bus.out_sat, 0);
    chk("ones_ch",  bus.out_ch, 0);
    chk("ones_last", bus.out_last, 0);
    @(posedge clk); #1;

    // all -1: floor rounding
    xfer1(1'b0, kconst(-1));
    e = '{-1,-2,-1,-1, -2,-3,-1,-2, -1,-2,-1,-1, -1,-2,-1,-1};
    chk("neg_fo", bus.filter_out, pk12(e));
    chk("neg_sat", bus.out_sat, 0);
    chk("neg_ch", bus.out_ch, 1);
    @(posedge clk); #1;

    // all 127: fits in 12 bits, clips in 6 bits
    xfer1(1'b0, kconst(127));
    e = '{127,190,63,127, 190,285,95,190, 63,94,31,63, 127,190,63,127};
    chk("big_fo", bus.filter_out, pk12(e));
    chk("big_u11", bus.filter_out[120 +: 12], 285);
    chk("big_sat", bus.out_sat, 0);
    chk("big_ch", bus.out_ch, 2);
    chk("w6_u00", bus6.filter_out[90 +: 6], 31);
    chk("w6_u11", bus6.filter_out[60 +: 6], 31);
    chk("w6_sat", bus6.out_sat, 1);
    @(posedge clk); #1;

    // bypass, g(r,c) = 3r+c-4
    for (int i = 0; i < 9; i++) fk[i*8 +: 8] = 8'(i - 4);
    xfer1(1'b1, fk);
    e = '{-4,-3,-2,0, -1,0,1,0, 2,3,4,0, 0,0,0,0};
    chk("byp_fo", bus.filter_out, pk12(e));
    chk("byp_sat", bus.out_sat, 0);
    chk("byp_ch", bus.out_ch, 3);
    chk("byp_last", bus.out_last, 1);
    @(posedge clk); #1;

    // 9-beat stream with random backpressure; beat b is bypass of const b+1
    do_reset();
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 300 && rx < 9; cyc++) begin
      in_valid  = (tx < 9);
      in_mode   = 1'b1;
      filter    = kconst(tx + 1);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.out_valid) begin
        chk("strm_extra", rx < 9, 1);
        chk("strm_fo",   bus.filter_out, bp_const(rx + 1));
        chk("strm_ch",   bus.out_ch, rx % 4);
        chk("strm_last", bus.out_last, (rx % 4) == 3);
        if (out_ready) rx++;
      end
      if (in_valid && bus.in_ready) tx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("strm_rx", rx, 9);
    chk("strm_tx", tx, 9);

    // fill both stages, then reset mid-stream
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b1; filter = kconst(5);
    @(posedge clk); #1;
    filter = kconst(6);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_irdy", bus.in_ready, 0);
    chk("full_ovalid", bus.out_valid, 1);
    chk("full_fo", bus.filter_out, bp_const(5));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ovalid", bus.out_valid, 0);
    chk("mrst_irdy", bus.in_ready, 1);
    chk("mrst_fo", bus.filter_out, 0);
    @(posedge clk); #1;
    xfer1(1'b1, kconst(7));
    chk("mrst_ch", bus.out_ch, 0);
    chk("mrst_data", bus.filter_out, bp_const(7));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
